// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: two-stage valid/ready wrapper around a binary32 add/sub
// datapath. S1 registers the operands and S2 registers the classified result.
// The classifier covers NaN, infinity and zero inputs. Denormal inputs are
// treated as zero. Results that leave the normal range saturate to +/-inf or
// flush to +/-0.

// add_sub: normal-operand binary32 adder/subtractor, round-to-nearest-even.
// Special inputs are not handled here; the wrapper's classifier overrides them.
module add_sub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);
    logic               sa, sbe, sl, swap;
    logic [7:0]         el, es, d;
    logic [23:0]        ml, ms;
    logic [26:0]        lal, sal, sh, nrm;
    logic               lost;
    logic [27:0]        sum;
    logic [4:0]         n;
    logic [23:0]        mant;
    logic [24:0]        mr;
    logic               rb, st, up;
    logic signed [9:0]  e;

    // Align, add/subtract, normalise and round. Guard/round bits plus one
    // sticky bit are enough because a large cancellation only happens
    // when the exponents differ by at most one, and then no bits are lost.
    always_comb begin
        sa        = a[31];
        sbe       = b[31] ^ op;
        // Larger magnitude goes on the left. Exponent-then-fraction compares
        // as one integer.
        swap      = (b[30:0] > a[30:0]);
        el        = swap ? b[30:23] : a[30:23];
        es        = swap ? a[30:23] : b[30:23];
        ml        = {1'b1, (swap ? b[22:0] : a[22:0])};
        ms        = {1'b1, (swap ? a[22:0] : b[22:0])};
        sl        = swap ? sbe : sa;
        d         = el - es;
        lal       = {ml, 3'b000};
        sh        = '0;
        lost      = 1'b0;
        nrm       = '0;
        n         = '0;
        mant      = '0;
        rb        = 1'b0;
        st        = 1'b0;
        e         = '0;
        result    = '0;
        overflow  = 1'b0;
        underflow = 1'b0;

        if (d >= 8'd27) begin
            // The small operand lies entirely below the sticky position.
            sal = 27'd1;
        end else begin
            sh   = {ms, 3'b000} >> d;
            lost = |({ms, 3'b000} & ~({27{1'b1}} << d));
            sal  = {sh[26:1], sh[0] | lost};
        end

        if (sa == sbe)
            sum = {1'b0, lal} + {1'b0, sal};
        else
            sum = {1'b0, lal} - {1'b0, sal};

        // Leading-one search. The highest set bit wins.
        for (int i = 0; i < 27; i++)
            if (sum[i]) n = 5'(26 - i);

        if (sum[27]) begin
            mant = sum[27:4];
            rb   = sum[3];
            st   = |sum[2:0];
            e    = $signed({2'b00, el}) + 10'sd1;
        end else begin
            nrm  = sum[26:0] << n;
            mant = nrm[26:3];
            rb   = nrm[2];
            st   = |nrm[1:0];
            e    = $signed({2'b00, el}) - $signed({5'b00000, n});
        end

        up = rb & (st | mant[0]);
        mr = {1'b0, mant} + {24'd0, up};
        if (mr[24]) begin
            mant = mr[24:1];
            e    = e + 10'sd1;
        end else begin
            mant = mr[23:0];
        end

        if (sum == 28'd0) begin
            // Exact cancellation gives +0.
            result = '0;
        end else if (e >= 10'sd255) begin
            overflow = 1'b1;
            result   = {sl, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            underflow = 1'b1;
            result    = {sl, 31'd0};
        end else begin
            result = {sl, e[7:0], mant[22:0]};
        end
    end
endmodule

module fp_addsub_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        s1_valid_q, op_q;
    logic [31:0] a_q, b_q;
    logic        s2_valid_q, ovf_q, udf_q, inv_q;
    logic [31:0] res_q;
    logic [31:0] res_d;
    logic        ovf_d, udf_d, inv_d;
    logic        s2_adv;

    logic [31:0] as_res;
    logic        as_ovf, as_udf;
    logic        sbe, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    // Ready chains combinationally from the consumer with no skid buffer.
    // This keeps one operation per cycle under back-pressure.
    assign s2_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;

    assign out_valid = s2_valid_q;
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign invalid   = inv_q;

    add_sub u_add_sub (
        .a         (a_q),
        .b         (b_q),
        .op        (op_q),
        .result    (as_res),
        .overflow  (as_ovf),
        .underflow (as_udf)
    );

    // Special-case classifier in parallel with the adder. Its priority is
    // NaN, then infinity, then zero or denormal, then the adder result.
    always_comb begin
        sbe    = b_q[31] ^ op_q;
        a_nan  = (&a_q[30:23]) && (|a_q[22:0]);
        b_nan  = (&b_q[30:23]) && (|b_q[22:0]);
        a_inf  = (&a_q[30:23]) && !(|a_q[22:0]);
        b_inf  = (&b_q[30:23]) && !(|b_q[22:0]);
        a_zero = !(|a_q[30:23]);
        b_zero = !(|b_q[30:23]);
        res_d  = as_res;
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        inv_d  = 1'b0;
        if (a_nan || b_nan) begin
            res_d = QNAN;
            inv_d = 1'b1;
        end else if (a_inf && b_inf) begin
            if (a_q[31] != sbe) begin
                res_d = QNAN;
                inv_d = 1'b1;
            end else begin
                res_d = {a_q[31], 8'hFF, 23'd0};
            end
        end else if (a_inf) begin
            res_d = {a_q[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
            res_d = {sbe, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            res_d = {a_q[31] & sbe, 31'd0};
        end else if (a_zero) begin
            res_d = {sbe, b_q[30:0]};
        end else if (b_zero) begin
            res_d = a_q;
        end else if (as_ovf) begin
            res_d = {as_res[31], 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else if (as_udf) begin
            res_d = {as_res[31], 31'd0};
            udf_d = 1'b1;
        end
    end

    // S1 operand register. The valid bit drops when S1 drains without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

    // S2 result register. Result and flags move only on a load, so they
    // hold steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
                udf_q <= udf_d;
                inv_q <= inv_d;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe. The reference model adds the operands as exact
// wide integers on a 2^-149 grid and then rounds to nearest-even.
module tb_fp_addsub_pipe;
    logic        clk, rst_n, in_valid, in_ready, op, out_valid, out_ready;
    logic        overflow, underflow, invalid;
    logic [31:0] a, b, result;

    int checks = 0;
    int passes = 0;
    logic [34:0] expq[$];

    fp_addsub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: returns {overflow, underflow, invalid, result}.
    function automatic logic [34:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic o);
        logic sx, sy, s;
        logic [7:0] ex, ey;
        logic xnan, ynan, xinf, yinf, xz, yz;
        logic [299:0] mx, my, m, q, rem, half, one;
        int p, sh, e;
        sx = x[31]; sy = y[31] ^ o;
        ex = x[30:23]; ey = y[30:23];
        xnan = (ex == 8'hFF) && (x[22:0] != 0);
        ynan = (ey == 8'hFF) && (y[22:0] != 0);
        xinf = (ex == 8'hFF) && (x[22:0] == 0);
        yinf = (ey == 8'hFF) && (y[22:0] == 0);
        xz = (ex == 8'h00); yz = (ey == 8'h00);
        if (xnan || ynan) return {3'b001, 32'h7FC00000};
        if (xinf && yinf) return (sx != sy) ? {3'b001, 32'h7FC00000} : {3'b000, sx, 8'hFF, 23'd0};
        if (xinf) return {3'b000, sx, 8'hFF, 23'd0};
        if (yinf) return {3'b000, sy, 8'hFF, 23'd0};
        if (xz && yz) return {3'b000, sx & sy, 31'd0};
        if (xz) return {3'b000, sy, y[30:0]};
        if (yz) return {3'b000, x};
        one = 300'd1;
        mx = 300'({1'b1, x[22:0]}) << (int'(ex) - 1);
        my = 300'({1'b1, y[22:0]}) << (int'(ey) - 1);
        if (sx == sy) begin m = mx + my; s = sx; end
        else if (mx >= my) begin m = mx - my; s = sx; end
        else begin m = my - mx; s = sy; end
        if (m == 0) return 35'd0;
        p = 0;
        for (int i = 0; i < 300; i++) if (m[i]) p = i;
        if (p < 23) return {3'b010, s, 31'd0};
        sh = p - 23;
        q = m >> sh;
        rem = m & ((one << sh) - one);
        half = (sh > 0) ? (one << (sh - 1)) : 300'd0;
        if (sh > 0 && (rem > half || (rem == half && q[0]))) q = q + one;
        e = p - 22;
        if (q[24]) begin q = q >> 1; e = e + 1; end
        if (e >= 255) return {3'b100, s, 8'hFF, 23'd0};
        return {3'b000, s, e[7:0], q[22:0]};
    endfunction

    task automatic gen_pair(output logic [31:0] ra, output logic [31:0] rb, output logic rop);
        int ea, eb, mode;
        logic [31:0] sp [6];
        sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7F800000;
        sp[3] = 32'hFF800000; sp[4] = 32'h7FC00123; sp[5] = 32'h00012345;
        ea = int'($urandom_range(1, 254));
        mode = int'($urandom_range(0, 9));
        if (mode < 5) eb = ea + int'($urandom_range(0, 8)) - 4;
        else eb = int'($urandom_range(1, 254));
        if (eb < 1) eb = 1;
        if (eb > 254) eb = 254;
        ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
        rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
        if (mode == 7) rb = {rb[31], ra[30:0]};
        if (mode == 8) ra = sp[$urandom_range(0, 5)];
        if (mode == 9) rb = sp[$urandom_range(0, 5)];
        rop = 1'($urandom_range(0, 1));
    endtask

    // One clock of stimulus. Inputs change at negedge and outputs are
    // observed 1 ns later, well away from the rising edge.
    task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                       input logic ior, output logic acc, output logic ov, output logic [34:0] obs);
        @(negedge clk);
        in_valid = iv; a = ia; b = ib; op = iop; out_ready = ior;
        #1;
        acc = iv && in_ready;
        ov  = out_valid;
        obs = {overflow, underflow, invalid, result};
        if (acc) expq.push_back(ref_model(ia, ib, iop));
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++;
        if ({overflow, underflow, invalid, result} !== 35'd0)
            $display("FAIL reset_outputs: got %h expected 0", {overflow, underflow, invalid, result});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    endtask

    task automatic test_basic;
        logic acc, ov;
        logic [34:0] obs, e;
        logic [34:0] want [2];
        want[0] = {3'b000, 32'h40400000};
        want[1] = {3'b000, 32'hBF800000};
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 32'h3F800000, 32'h40000000, 1'(k), 1'b1, acc, ov, obs);
            checks++;
            if (acc !== 1'b1) $display("FAIL basic_accept: got %b expected 1", acc); else passes++;
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, ov, obs);
            checks++;
            if (ov !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", ov); else passes++;
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, ov, obs);
            checks++;
            if (ov !== 1'b1 || obs !== want[k])
                $display("FAIL basic_result%0d: got valid %b %h expected valid 1 %h", k, ov, obs, want[k]);
            else passes++;
            if (expq.size() > 0) e = expq.pop_front();
        end
    endtask

    task automatic test_special;
        logic [31:0] ta [11], tb_ [11];
        logic        to [11];
        logic [34:0] te [11];
        logic acc, ov, got;
        logic [34:0] obs, e;
        ta[0]  = 32'h7F800000; tb_[0]  = 32'h7F800000; to[0]  = 1; te[0]  = {3'b001, 32'h7FC00000};
        ta[1]  = 32'h7FC00000; tb_[1]  = 32'h3F800000; to[1]  = 0; te[1]  = {3'b001, 32'h7FC00000};
        ta[2]  = 32'h00000000; tb_[2]  = 32'hC0000000; to[2]  = 0; te[2]  = {3'b000, 32'hC0000000};
        ta[3]  = 32'h00000000; tb_[3]  = 32'h00000000; to[3]  = 1; te[3]  = {3'b000, 32'h00000000};
        ta[4]  = 32'h7F7FFFFF; tb_[4]  = 32'h7F7FFFFF; to[4]  = 0; te[4]  = {3'b100, 32'h7F800000};
        ta[5]  = 32'h00800000; tb_[5]  = 32'h00800001; to[5]  = 1; te[5]  = {3'b010, 32'h80000000};
        ta[6]  = 32'h3F800000; tb_[6]  = 32'h7F800000; to[6]  = 1; te[6]  = {3'b000, 32'hFF800000};
        ta[7]  = 32'h80000000; tb_[7]  = 32'h80000000; to[7]  = 0; te[7]  = {3'b000, 32'h80000000};
        ta[8]  = 32'h3F800000; tb_[8]  = 32'h00000001; to[8]  = 0; te[8]  = {3'b000, 32'h3F800000};
        ta[9]  = 32'hFF800000; tb_[9]  = 32'h7F800000; to[9]  = 1; te[9]  = {3'b000, 32'hFF800000};
        ta[10] = 32'h3F800000; tb_[10] = 32'h33800000; to[10] = 0; te[10] = {3'b000, 32'h3F800000};
        for (int k = 0; k < 11; k++) begin
            got = 1'b0;
            acc = 1'b0;
            for (int t = 0; t < 10 && !acc; t++) cyc(1'b1, ta[k], tb_[k], to[k], 1'b1, acc, ov, obs);
            for (int t = 0; t < 10 && !got; t++) begin
                cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, ov, obs);
                got = ov;
            end
            checks++;
            if (!got || obs !== te[k])
                $display("FAIL special_%0d: got valid %b %h expected %h", k, got, obs, te[k]);
            else passes++;
            if (expq.size() > 0) e = expq.pop_front();
        end
    endtask

    task automatic test_back_to_back;
        logic acc, ov;
        logic [34:0] obs, e;
        logic [31:0] ra, rb;
        logic rop;
        for (int c = 0; c < 12; c++) begin
            gen_pair(ra, rb, rop);
            cyc(c < 8, ra, rb, rop, 1'b1, acc, ov, obs);
            if (c < 8) begin
                checks++;
                if (acc !== 1'b1) $display("FAIL b2b_in_ready_c%0d: got %b expected 1", c, acc); else passes++;
            end
            checks++;
            if (ov !== (c >= 2 && c < 10)) $display("FAIL b2b_valid_c%0d: got %b expected %b", c, ov, (c >= 2 && c < 10));
            else passes++;
            if (ov && expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (obs !== e) $display("FAIL b2b_result_c%0d: got %h expected %h", c, obs, e); else passes++;
            end
        end
    endtask

    task automatic test_backpressure;
        logic acc, ov;
        logic [34:0] obs, e, held;
        logic [31:0] ra, rb;
        logic rop;
        int drained = 0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            gen_pair(ra, rb, rop);
            cyc(1'b1, ra, rb, rop, 1'b0, acc, ov, obs);
            checks++;
            if (acc !== (c < 2)) $display("FAIL bp_in_ready_c%0d: got %b expected %b", c, acc, (c < 2)); else passes++;
            if (c == 2) held = obs;
            if (c > 2) begin
                checks++;
                if (ov !== 1'b1 || obs !== held) $display("FAIL bp_stable_c%0d: got %b %h expected 1 %h", c, ov, obs, held);
                else passes++;
            end
        end
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, ov, obs);
            if (ov && expq.size() > 0) begin
                e = expq.pop_front();
                drained++;
                checks++;
                if (obs !== e) $display("FAIL bp_result_%0d: got %h expected %h", drained, obs, e); else passes++;
            end else if (ov) begin
                drained++;
            end
        end
        checks++;
        if (drained != 2 || expq.size() != 0)
            $display("FAIL bp_count: got %0d results expected 2 (left %0d)", drained, expq.size());
        else passes++;
    endtask

    task automatic test_random;
        logic acc, ov, iv, ior, rop;
        logic [34:0] obs, e;
        logic [31:0] ra, rb;
        int sent = 0, got = 0, n = 0, bad = 0;
        gen_pair(ra, rb, rop);
        while ((sent < 300 || expq.size() > 0) && n < 4000) begin
            iv  = (sent < 300) && ($urandom_range(0, 9) < 8);
            ior = ($urandom_range(0, 9) < 7);
            cyc(iv, ra, rb, rop, ior, acc, ov, obs);
            if (ov && ior) begin
                got++;
                if (expq.size() > 0) e = expq.pop_front(); else e = 'x;
                checks++;
                if (obs !== e) begin
                    bad++;
                    if (bad < 10) $display("FAIL random_%0d: got %h expected %h", got, obs, e);
                end else passes++;
            end
            if (acc) begin
                sent++;
                gen_pair(ra, rb, rop);
            end
            n++;
        end
        checks++;
        if (sent != 300 || got != 300 || expq.size() != 0)
            $display("FAIL random_count: sent %0d got %0d expected 300 each", sent, got);
        else passes++;
    endtask

    task automatic test_reset_midflight;
        logic acc, ov;
        logic [34:0] obs, e;
        cyc(1'b1, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, acc, ov, obs);
        cyc(1'b1, 32'h40400000, 32'h3F800000, 1'b1, 1'b0, acc, ov, obs);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc, ov, obs);
        checks++;
        if (ov !== 1'b1) $display("FAIL midrst_full: got %b expected 1", ov); else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || {overflow, underflow, invalid, result} !== 35'd0)
            $display("FAIL midrst_outputs: got %b %h expected 0 0", out_valid, {overflow, underflow, invalid, result});
        else passes++;
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1, acc, ov, obs);
        checks++;
        if (acc !== 1'b1 || ov !== 1'b0) $display("FAIL midrst_accept: got acc %b valid %b expected 1 0", acc, ov); else passes++;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, ov, obs);
        checks++;
        if (ov !== 1'b0) $display("FAIL midrst_early: got %b expected 0", ov); else passes++;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc, ov, obs);
        checks++;
        if (ov !== 1'b1 || obs !== {3'b000, 32'h40000000})
            $display("FAIL midrst_result: got %b %h expected 1 40000000", ov, obs);
        else passes++;
        if (expq.size() > 0) e = expq.pop_front();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
